// File: rtl/cv32e40p_pkg.sv
// Shared types and limits for the instruction fetch unit.
package cv32e40p_pkg;

  typedef enum logic {
    ALIGNED   = 1'b0,
    UNALIGNED = 1'b1
  } fetch_align_e;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_WAIT = 1'b1
  } fetch_req_e;

  localparam int unsigned FETCH_DEPTH_MAX = 16;
  localparam int unsigned FETCH_CNT_W     = $clog2(FETCH_DEPTH_MAX + 1);

  function automatic logic is_compressed(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

endpackage

// File: rtl/cv32e40p_fetch_fifo.sv
// Instruction word FIFO with head and head+1 peek; pointers wrap modulo DEPTH.
module cv32e40p_fetch_fifo
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [WIDTH-1:0]       head1_o,
  output logic [FETCH_CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]       rptr_q, wptr_q;
  logic [FETCH_CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wrap_inc(wptr_q);
      if (pop_i)  rptr_q <= wrap_inc(rptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + FETCH_CNT_W'(1);
        2'b01:   count_q <= count_q - FETCH_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign head1_o = mem_q[wrap_inc(rptr_q)];
  assign count_o = count_q;

endmodule

// File: rtl/cv32e40p_fetch_unit.sv
// OBI fetch unit: request FSM, outstanding/discard counters, FIFO and 16/32-bit aligner.
// Define CV32E40P_FETCH_ERR_EN to carry instr_err_i through the FIFO to fetch_err_o.
//   state     | meaning
//   REQ_IDLE  | no request pending; issue when the request rule allows
//   REQ_WAIT  | request issued, holding req/addr until granted or branch
module cv32e40p_fetch_unit
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic        instr_err_i,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_compressed_o,
  output logic        fetch_err_o,
  output logic        busy_o
);

`ifdef CV32E40P_FETCH_ERR_EN
  localparam int unsigned ENTRY_W = 33;
`else
  localparam int unsigned ENTRY_W = 32;
`endif

  fetch_req_e             req_state_q, req_state_d;
  fetch_align_e           align_q, align_d;
  logic [31:0]            fetch_addr_q, fetch_addr_d;
  logic [31:0]            pc_q, pc_d;
  logic [FETCH_CNT_W-1:0] outst_q, outst_d, discard_q, discard_d;
  logic [FETCH_CNT_W-1:0] fifo_count;
  logic [FETCH_CNT_W:0]   fill_level;
  logic [ENTRY_W-1:0]     head, head1, push_data;
  logic [31:0]            w, w1, out_instr;
  logic                   err_w, err_w1, out_err;
  logic                   can_issue, grant, push, pop, have, compressed;
  logic                   unused_in;

  // Words in the FIFO plus words still on their way must never exceed DEPTH.
  assign fill_level = {1'b0, fifo_count} + {1'b0, outst_q};
  assign can_issue  = req_i && (outst_q < FETCH_CNT_W'(MAX_OUTSTANDING)) &&
                      (fill_level < (FETCH_CNT_W + 1)'(DEPTH));

  always_comb begin
    instr_req_o = !branch_i && ((req_state_q == REQ_WAIT) || can_issue);
    req_state_d = (instr_req_o && !instr_gnt_i) ? REQ_WAIT : REQ_IDLE;
  end

  assign grant = instr_req_o && instr_gnt_i;
  assign push  = instr_rvalid_i && (discard_q == '0) && !branch_i;

  always_comb begin
    case ({grant, instr_rvalid_i})
      2'b10:   outst_d = outst_q + FETCH_CNT_W'(1);
      2'b01:   outst_d = outst_q - FETCH_CNT_W'(1);
      default: outst_d = outst_q;
    endcase
    discard_d = discard_q;
    if (branch_i)                               discard_d = outst_q - FETCH_CNT_W'(instr_rvalid_i);
    else if (instr_rvalid_i && discard_q != '0) discard_d = discard_q - FETCH_CNT_W'(1);
    fetch_addr_d = fetch_addr_q;
    if (branch_i)   fetch_addr_d = {branch_addr_i[31:2], 2'b00};
    else if (grant) fetch_addr_d = fetch_addr_q + 32'd4;
  end

`ifdef CV32E40P_FETCH_ERR_EN
  assign push_data = {instr_err_i, instr_rdata_i};
  assign err_w     = head[32];
  assign err_w1    = head1[32];
`else
  assign push_data = instr_rdata_i;
  assign err_w     = 1'b0;
  assign err_w1    = 1'b0;
`endif
  assign w         = head[31:0];
  assign w1        = head1[31:0];
  assign unused_in = ^{head1[ENTRY_W-1:16], instr_err_i, branch_addr_i[0]};

  cv32e40p_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (branch_i),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .head_o  (head),
    .head1_o (head1),
    .count_o (fifo_count)
  );

  always_comb begin
    have       = 1'b0;
    out_instr  = '0;
    out_err    = 1'b0;
    compressed = 1'b0;
    pop        = 1'b0;
    align_d    = align_q;
    pc_d       = pc_q;
    if (align_q == ALIGNED) begin
      have       = fifo_count != '0;
      compressed = is_compressed(w[1:0]);
      out_instr  = compressed ? {16'h0, w[15:0]} : w;
      out_err    = err_w;
    end else begin
      compressed = is_compressed(w[17:16]);
      if (compressed) begin
        have      = fifo_count != '0;
        out_instr = {16'h0, w[31:16]};
        out_err   = err_w;
      end else begin
        // Instruction straddles two words: needs the next entry too.
        have      = fifo_count >= FETCH_CNT_W'(2);
        out_instr = {w1[15:0], w[31:16]};
        out_err   = err_w | err_w1;
      end
    end
    instr_valid_o = have && !branch_i;
    if (branch_i) begin
      align_d = branch_addr_i[1] ? UNALIGNED : ALIGNED;
      pc_d    = {branch_addr_i[31:1], 1'b0};
    end else if (instr_valid_o && instr_ready_i) begin
      pc_d = pc_q + (compressed ? 32'd2 : 32'd4);
      pop  = !((align_q == ALIGNED) && compressed);
      if (compressed) align_d = (align_q == ALIGNED) ? UNALIGNED : ALIGNED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_state_q  <= REQ_IDLE;
      align_q      <= ALIGNED;
      fetch_addr_q <= '0;
      pc_q         <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
    end else begin
      req_state_q  <= req_state_d;
      align_q      <= align_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
    end
  end

  assign instr_addr_o       = fetch_addr_q;
  assign instr_pc_o         = pc_q;
  assign instr_o            = instr_valid_o ? out_instr : '0;
  assign instr_compressed_o = instr_valid_o && compressed;
  assign fetch_err_o        = instr_valid_o && out_err;
  assign busy_o             = outst_q != '0;

endmodule

// File: tb/tb_cv32e40p_fetch_unit.sv
// Bench for cv32e40p_fetch_unit: OBI memory responder plus a byte-addressed instruction stream model.
module tb_cv32e40p_fetch_unit;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
`ifdef CV32E40P_FETCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_i = 1'b0, branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_valid_o, instr_ready_i = 1'b0;
  logic [31:0] instr_o, instr_pc_o;
  logic        instr_compressed_o, fetch_err_o, busy_o;

  always #5 clk = ~clk;

  cv32e40p_fetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_err_i(instr_err_i), .instr_rdata_i(instr_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .instr_compressed_o(instr_compressed_o), .fetch_err_o(fetch_err_o),
    .busy_o(busy_o)
  );

  logic [31:0] mem  [logic [31:0]];
  bit          errw [logic [31:0]];
  logic [31:0] pend_a[$];
  int          pend_t[$];
  logic [31:0] hs_pc[$], hs_instr[$], hs_err[$];
  int          total = 0, bad = 0, cyc = 0, br_cyc = 0, first_valid = -1, hs_total = 0;
  int          rdy_mode = 0, lat_lo = 1, lat_hi = 1, err_pct = 0;
  bit          gnt_rand = 1'b0, req_en = 1'b0, hold_prev = 1'b0;
  logic [31:0] exp_addr = '0, model_pc = '0, hold_addr = '0, last_addr = '0;
  logic        last_req = 1'b0, last_busy = 1'b0, last_valid = 1'b0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [31:0] wa = {a[31:2], 2'b00};
    if (!mem.exists(wa)) begin
      mem[wa]  = $urandom;
      errw[wa] = ($urandom_range(0, 99) < err_pct);
    end
    return mem[wa];
  endfunction

  function automatic bit rderr(input logic [31:0] a);
    logic [31:0] d = rd(a);
    return errw[{a[31:2], 2'b00}] && (d === d);
  endfunction

  function automatic logic [15:0] half(input logic [31:0] a);
    logic [31:0] d = rd(a);
    return a[1] ? d[31:16] : d[15:0];
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] d, input bit e);
    mem[a]  = d;
    errw[a] = e;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected instruction at model_pc, decoded straight from the byte-addressed memory.
  task automatic model_check();
    logic [15:0] lo = half(model_pc);
    logic [15:0] hi;
    bit          comp = (lo[1:0] != 2'b11);
    logic [31:0] ei;
    bit          ee;
    if (comp) begin
      ei = {16'h0, lo};
      ee = rderr(model_pc);
    end else begin
      hi = half(model_pc + 32'd2);
      ei = {hi, lo};
      ee = rderr(model_pc) | rderr(model_pc + 32'd2);
    end
    if (!ERR_EN) ee = 1'b0;
    chk("hs_pc", instr_pc_o, model_pc);
    chk("hs_instr", instr_o, ei);
    chk("hs_comp", instr_compressed_o, comp);
    chk("hs_err", fetch_err_o, ee);
    hs_pc.push_back(instr_pc_o);
    hs_instr.push_back(instr_o);
    hs_err.push_back(fetch_err_o);
    hs_total++;
    model_pc += comp ? 32'd2 : 32'd4;
  endtask

  task automatic step(input bit br = 1'b0, input logic [31:0] ba = 32'h0);
    bit hs;
    @(negedge clk);
    req_i = req_en; branch_i = br; branch_addr_i = ba;
    instr_ready_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    #1;
    last_req = instr_req_o; last_addr = instr_addr_o; last_busy = busy_o; last_valid = instr_valid_o;
    chk("busy", busy_o, pend_a.size() != 0);
    chk("req_cap", instr_req_o && (pend_a.size() >= MAXO), 0);
    if (br) begin
      chk("br_valid", instr_valid_o, 0);
      chk("br_req", instr_req_o, 0);
    end else if (hold_prev) begin
      chk("req_hold", instr_req_o, 1);
      chk("addr_hold", instr_addr_o, hold_addr);
    end else if (!req_en) begin
      chk("req_gate", instr_req_o, 0);
    end
    hs = instr_valid_o && instr_ready_i;
    if (instr_valid_o && first_valid < 0) first_valid = cyc;
    if (hs) model_check();
    if (pend_a.size() != 0 && pend_t[0] <= cyc && (!gnt_rand || $urandom_range(0, 3) != 0)) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = rd(pend_a[0]);
      instr_err_i    = rderr(pend_a[0]);
      void'(pend_a.pop_front());
      void'(pend_t.pop_front());
    end
    if (instr_req_o && (!gnt_rand || $urandom_range(0, 2) != 0)) begin
      instr_gnt_i = 1'b1;
      chk("gnt_addr", instr_addr_o, exp_addr);
      pend_a.push_back(instr_addr_o);
      pend_t.push_back(cyc + $urandom_range(lat_lo, lat_hi));
      exp_addr += 32'd4;
    end
    hold_prev = instr_req_o && !instr_gnt_i;
    hold_addr = instr_addr_o;
    if (br) begin
      exp_addr = {ba[31:2], 2'b00};
      model_pc = {ba[31:1], 1'b0};
      br_cyc = cyc;
      first_valid = -1;
      hs_pc.delete(); hs_instr.delete(); hs_err.delete();
    end
    cyc++;
  endtask

  task automatic drain();
    req_en = 1'b0; rdy_mode = 0; gnt_rand = 1'b0; lat_lo = 1; lat_hi = 1;
    repeat (8) step();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", instr_req_o, 0);
    chk("rst_addr", instr_addr_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", instr_pc_o, 0);
    chk("rst_comp", instr_compressed_o, 0);
    chk("rst_err", fetch_err_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_n = 1'b1;

    // Aligned 32-bit stream, zero-wait memory
    for (int i = 0; i < 32; i++) put(32'h100 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 20), 1'b0);
    req_en = 1'b1;
    step(1'b1, 32'h100);
    step();
    chk("t1_req", last_req, 1);
    chk("t1_addr", last_addr, 32'h100);
    repeat (10) step();
    chk("t1_latency", first_valid - br_cyc, 3);
    chk("t1_count", hs_pc.size(), 9);
    chk("t1_pc0", hs_pc[0], 32'h100);
    chk("t1_pc1", hs_pc[1], 32'h104);
    chk("t1_instr0", hs_instr[0], 32'h0000_0013);

    // Compressed at +2 then aligned 32-bit
    drain();
    put(32'h100, 32'h0001_1234, 1'b0);
    put(32'h104, 32'h00A0_0513, 1'b0);
    req_en = 1'b1;
    step(1'b1, 32'h102);
    repeat (8) step();
    chk("t2_instr0", hs_instr[0], 32'h0000_0001);
    chk("t2_pc0", hs_pc[0], 32'h102);
    chk("t2_instr1", hs_instr[1], 32'h00A0_0513);
    chk("t2_pc1", hs_pc[1], 32'h104);

    // 32-bit instruction straddling two words
    drain();
    put(32'h200, 32'h0513_1111, 1'b0);
    put(32'h204, 32'h5555_00A0, 1'b0);
    req_en = 1'b1;
    step(1'b1, 32'h202);
    repeat (8) step();
    chk("t3_latency", first_valid - br_cyc, 4);
    chk("t3_instr0", hs_instr[0], 32'h00A0_0513);
    chk("t3_pc0", hs_pc[0], 32'h202);
    chk("t3_pc1", hs_pc[1], 32'h206);
    chk("t3_instr1", hs_instr[1], 32'h0000_5555);

    // Branch with two slow responses in flight: both must be dropped
    drain();
    put(32'h380, 32'h0001_0001, 1'b0);
    put(32'h384, 32'h0001_0001, 1'b0);
    put(32'h400, 32'h00B0_0593, 1'b0);
    req_en = 1'b1; lat_lo = 3; lat_hi = 3;
    step(1'b1, 32'h380);
    step();
    step();
    step(1'b1, 32'h400);
    repeat (14) step();
    chk("t4_pc0", hs_pc[0], 32'h400);
    chk("t4_instr0", hs_instr[0], 32'h00B0_0593);

    // Back-pressure: FIFO fills, requests stop, nothing lost on release
    drain();
    req_en = 1'b1; rdy_mode = 1;
    step(1'b1, 32'h600);
    repeat (10) step();
    chk("t5_req_off", last_req, 0);
    chk("t5_busy", last_busy, 0);
    chk("t5_valid", last_valid, 1);
    rdy_mode = 0;
    repeat (20) step();
    chk("t5_pc0", hs_pc[0], 32'h600);
    chk("t5_progress", hs_pc.size() >= 10, 1);

    // Bus error on word 0x304
    drain();
    put(32'h300, 32'h0513_0001, 1'b0);
    put(32'h304, 32'h4501_00A0, 1'b1);
    put(32'h308, 32'h0000_0013, 1'b0);
    put(32'h30C, 32'h0000_0013, 1'b0);
    req_en = 1'b1;
    step(1'b1, 32'h300);
    repeat (10) step();
    chk("t6_pc0", hs_pc[0], 32'h300);
    chk("t6_pc1", hs_pc[1], 32'h302);
    chk("t6_pc2", hs_pc[2], 32'h306);
    chk("t6_pc3", hs_pc[3], 32'h308);
    chk("t6_err0", hs_err[0], 0);
    chk("t6_err1", hs_err[1], ERR_EN);
    chk("t6_err2", hs_err[2], ERR_EN);
    chk("t6_err3", hs_err[3], 0);

    // Randomised traffic: branches, back-pressure, grant/response latency, errors
    err_pct = 10; gnt_rand = 1'b1; lat_lo = 1; lat_hi = 3; rdy_mode = 2;
    repeat (3000) begin
      req_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 24) == 0) step(1'b1, 32'h1000 + (32'($urandom_range(0, 511)) << 1));
      else step();
    end
    rdy_mode = 0; gnt_rand = 1'b0; lat_lo = 1; lat_hi = 1; req_en = 1'b1;
    repeat (20) step();
    chk("rand_progress", hs_total > 300, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_fetch_unit.md
# cv32e40p_fetch_unit

Parametrised instruction fetch unit: OBI instruction master with configurable outstanding-request depth, an instruction FIFO of configurable depth, and an aligner that emits whole 16/32-bit RISC-V instructions with their PC. It sits between the instruction bus and the IF/ID pipeline register, in the same position as the prefetch buffer plus aligner pair. It adds multiple outstanding transactions, discarding of stale responses after a branch, and valid/ready output.

## Interface
- DEPTH, 4: FIFO entries (32-bit words); legal 2..16.
- MAX_OUTSTANDING, 2: OBI requests in flight; legal 1..DEPTH.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  1  fetch enable; when low, no new instr_req_o is issued.
- branch_i  in  1  redirect; flushes FIFO and aligner.
- branch_addr_i  in  32  redirect target; bit 0 ignored.
- instr_req_o / instr_addr_o  out  1 / 32  OBI request and word-aligned address.
- instr_gnt_i, instr_rvalid_i, instr_err_i  in  1 each  OBI grant, response valid, bus error.
- instr_rdata_i  in  32  OBI read data.
- instr_valid_o / instr_ready_i  out / in  1 / 1  output handshake.
- instr_o  out  32  aligned raw instruction; upper half is zero when compressed.
- instr_pc_o  out  32  PC of instr_o.
- instr_compressed_o  out  1  instr_o[1:0] != 2'b11.
- fetch_err_o  out  1  bus error attached to instr_o.
- busy_o  out  1  outstanding count != 0.

## Operation
- Reset values: instr_req_o=0, instr_addr_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, instr_compressed_o=0, fetch_err_o=0, busy_o=0. Fetch address register, outstanding count, discard count and aligner state are also cleared.
- Request rule: instr_req_o = req_i & !branch_i & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding < DEPTH).
  - Once asserted, instr_req_o and instr_addr_o stay stable until instr_gnt_i.
  - Exception: a branch abandons the ungranted request.
  - The fetch address advances by 4 on each grant.
- Outstanding counter: +1 on instr_req_o&instr_gnt_i, -1 on instr_rvalid_i. Both in the same cycle leaves it unchanged.
- Branch at cycle N:
  - FIFO cleared; aligner forced to ALIGNED if branch_addr_i[1]=0, else UNALIGNED. PC set to {branch_addr_i[31:1],1'b0}.
  - discard_cnt loads outstanding minus 1 if instr_rvalid_i is high in N, else outstanding.
  - In N+1, instr_req_o goes high with address {branch_addr_i[31:2],2'b00}.
- Responses arriving while discard_cnt != 0 decrement discard_cnt and are dropped. Otherwise {rdata, err} is pushed to the FIFO.
- Aligner states:
  - ALIGNED, head word w.
    - If compressed: emit w[15:0], PC+=2, go to UNALIGNED, no pop.
    - Else: emit w, PC+=4, pop.
  - UNALIGNED.
    - If w[17:16] != 2'b11: emit w[31:16], PC+=2, pop, go to ALIGNED.
    - Else: a second FIFO entry is required. Emit {w1[15:0], w[31:16]}, PC+=4, pop one, stay UNALIGNED. fetch_err_o = err(w) | err(w1).
- instr_valid_o is asserted only when the required entries are present and no branch is pending. State advances only on instr_valid_o & instr_ready_i.
- Simultaneous branch_i and handshake: the branch wins and the handshake is discarded.
- Simultaneous push and pop on a full FIFO is legal. A push when full cannot occur, by the request rule.

## Timing
- Combinational from FIFO head to instr_o, instr_pc_o, instr_compressed_o and instr_valid_o. No path from instr_rdata_i to outputs; the response is visible at earliest in the cycle after instr_rvalid_i.
- Branch to first instr_req_o: 1 cycle.
- Branch to first instr_valid_o with 0-wait gnt/rvalid: 3 cycles (unaligned 32-bit target: 4).
- Sustained throughput with gnt/rvalid always high and MAX_OUTSTANDING>=2: one instruction per cycle.
- Reset mid-operation clears all state immediately. Responses arriving after deassertion of reset are not expected.

## Configuration
- CV32E40P_FETCH_ERR_EN defined: the FIFO stores instr_err_i per entry (33 bits wide) and fetch_err_o propagates as above.
- Not defined: entries are 32 bits, instr_err_i is ignored, and fetch_err_o is tied to 0.

## Structure
- cv32e40p_pkg: add enum fetch_align_e {ALIGNED, UNALIGNED} and localparam FETCH_DEPTH_MAX=16.
- Sub-module cv32e40p_fetch_fifo:
  - Parameter DEPTH.
  - Ports: push, pop, flush, head and head+1 peek, count.
  - Read/write pointers wrap modulo DEPTH.
- The top level holds the request FSM, counters and aligner.

## Test plan
- Reset, req_i=1, branch to 0x100, zero-wait memory of 32-bit instrs → addresses 0x100, 0x104, …; PCs 0x100, 0x104 on consecutive cycles.
- Branch to 0x102, word@0x100=0x0001_xxxx (compressed at +2), word@0x104=0x00A0_0513 → emits 0x0001 @0x102, then 0x0513/0x00A0 sequence with correct PCs.
- Unaligned 32-bit: word@0x200=0x0513_xxxx, word@0x204=0xxxxx_00A0 from branch 0x202 → instr_o=0x00A0_0513, pc 0x202, next pc 0x206.
- Two requests outstanding, branch to 0x400 before responses, rvalid delayed 3 cycles → both stale responses dropped; first emitted PC 0x400.
- instr_ready_i=0 for 10 cycles with DEPTH=4 → at most 4 words buffered plus outstanding, instr_req_o deasserts, no data loss after release.
- With CV32E40P_FETCH_ERR_EN, instr_err_i=1 on word 0x304 → fetch_err_o=1 only for instructions overlapping 0x304.
